// File: rtl/game_state_tx.sv
// UART 8N1 transmitter for the pong game-state packet: snapshots ball position and
// scores on a frame boundary and sends SYNC, x_hi, x_lo, y_hi, y_lo, scores, checksum.
module game_state_tx #(
    parameter int unsigned CLKS_PER_BIT = 564,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        end_of_frame,
    input  logic        enable,
    input  logic [10:0] x_pos_of_ball,
    input  logic [10:0] y_pos_of_ball,
    input  logic [3:0]  points_player_1,
    input  logic [3:0]  points_player_2,
    output logic        tx,
    output logic        busy,
    output logic        packet_done
);

    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic [3:0]    p1_q, p1_d;
    logic [3:0]    p2_q, p2_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          bit_end;
    logic [7:0]    checksum;
    logic [7:0]    cur_byte;

    assign bit_end = (timer_q == T_LAST);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        x_d        = x_q;
        y_d        = y_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (end_of_frame && enable && !busy_q) begin
                    state_d    = START;
                    timer_d    = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    x_d        = x_pos_of_ball;
                    y_d        = y_pos_of_ball;
                    p1_d       = points_player_1;
                    p2_d       = points_player_2;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (byte_idx_q == 3'd6) begin
                        byte_idx_d = '0;
                        state_d    = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The pulse lands in the final stop-bit cycle, so it must be raised one edge early.
        if (state_q == STOP && byte_idx_q == 3'd5 && bit_end) begin
            done_d = 1'b0;
        end
        if (state_d == STOP && byte_idx_d == 3'd6 && timer_d == T_LAST) begin
            done_d = 1'b1;
        end
    end

    assign checksum = {5'b0, x_d[10:8]} ^ x_d[7:0] ^ {5'b0, y_d[10:8]} ^ y_d[7:0]
                    ^ {p1_d, p2_d};

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx_d)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = {5'b0, x_d[10:8]};
            3'd2:    cur_byte = x_d[7:0];
            3'd3:    cur_byte = {5'b0, y_d[10:8]};
            3'd4:    cur_byte = y_d[7:0];
            3'd5:    cur_byte = {p1_d, p2_d};
            3'd6:    cur_byte = checksum;
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    // Outputs are derived from next-state values so the line changes on the same edge as the FSM.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign packet_done = done_q;

endmodule

// File: tb/tb_game_state_tx.sv
// Bench for game_state_tx: a cycle-level waveform model built from the packet rules,
// compared against the DUT every cycle, plus directed scenarios and random traffic.
module tb_game_state_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eof = 1'b0;
    logic        en  = 1'b0;
    logic [10:0] x   = '0;
    logic [10:0] y   = '0;
    logic [3:0]  p1  = '0;
    logic [3:0]  p2  = '0;
    logic        tx;
    logic        busy;
    logic        packet_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_state_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk65MHz       (clk),
        .rst            (rst),
        .end_of_frame   (eof),
        .enable         (en),
        .x_pos_of_ball  (x),
        .y_pos_of_ball  (y),
        .points_player_1(p1),
        .points_player_2(p2),
        .tx             (tx),
        .busy           (busy),
        .packet_done    (packet_done)
    );

    function automatic logic [7:0] spec_byte(input logic [10:0] xv, input logic [10:0] yv,
                                             input logic [3:0] a, input logic [3:0] b,
                                             input int i);
        logic [7:0] by [7];
        by[0] = 8'hA5;
        by[1] = 8'(xv / 256);
        by[2] = 8'(xv % 256);
        by[3] = 8'(yv / 256);
        by[4] = 8'(yv % 256);
        by[5] = 8'(a * 16 + b);
        by[6] = by[1] ^ by[2] ^ by[3] ^ by[4] ^ by[5];
        return by[i];
    endfunction

    // Model: queue of {done, tx} per future busy cycle; empty queue means idle line.
    logic [1:0] exp_q [$];
    logic       m_tx    = 1'b1;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic       started = 1'b0;

    always @(posedge clk) begin : model
        logic [1:0] nxt;
        logic [7:0] b;
        if (rst) begin
            exp_q.delete();
            m_tx    <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            started <= 1'b1;
        end else begin
            if (eof && en && !m_busy) begin
                $display("packet x=%0d y=%0d p1=%0d p2=%0d t=%0t", x, y, p1, p2, $time);
                for (int i = 0; i < 7; i++) begin
                    b = spec_byte(x, y, p1, p2, i);
                    for (int c = 0; c < CPB; c++) exp_q.push_back(2'b00);
                    for (int k = 0; k < 8; k++)
                        for (int c = 0; c < CPB; c++) exp_q.push_back({1'b0, b[k]});
                    for (int c = 0; c < CPB; c++) exp_q.push_back(2'b01);
                end
                exp_q[exp_q.size()-1] = 2'b11;
            end
            if (exp_q.size() > 0) begin
                nxt = exp_q.pop_front();
                m_tx   <= nxt[0];
                m_busy <= 1'b1;
                m_done <= nxt[1];
            end else begin
                m_tx   <= 1'b1;
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({tx, busy, packet_done} !== {m_tx, m_busy, m_done}) begin
                errors++;
                if (errors < 20)
                    $display("FAIL cycle_cmp t=%0t tx/busy/done got %b%b%b want %b%b%b",
                             $time, tx, busy, packet_done, m_tx, m_busy, m_done);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic pulse_eof();
        eof = 1'b1;
        tick();
        eof = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle busy still %b after %0d cycles", busy, n);
        end
    endtask

    initial begin
        logic [7:0] nom [7];
        logic [7:0] mx  [7];
        int cnt;
        nom = '{8'hA5, 8'h01, 8'hF8, 8'h01, 8'h78, 8'h37, 8'hB7};
        mx  = '{8'hA5, 8'h07, 8'hFF, 8'h07, 8'hFF, 8'hFF, 8'hFF};

        // Reset, then end_of_frame with enable low must be ignored.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_lit("reset_tx", int'(tx), 1);
        check_lit("reset_busy", int'(busy), 0);
        check_lit("reset_done", int'(packet_done), 0);
        en = 1'b0;
        pulse_eof();
        repeat (500) tick();

        // Nominal packet with snapshot isolation and an ignored mid-packet frame pulse.
        for (int i = 0; i < 7; i++) begin
            check_lit($sformatf("model_nom_b%0d", i),
                      int'(spec_byte(11'd504, 11'd376, 4'd3, 4'd7, i)), int'(nom[i]));
            check_lit($sformatf("model_max_b%0d", i),
                      int'(spec_byte(11'd2047, 11'd2047, 4'd15, 4'd15, i)), int'(mx[i]));
        end
        en = 1'b1; x = 11'd504; y = 11'd376; p1 = 4'd3; p2 = 4'd7;
        pulse_eof();
        x = 11'd923; p1 = 4'd9; p2 = 4'd9;
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            eof = (cnt == 99);
            tick();
        end
        eof = 1'b0;
        check_lit("busy_cycles", cnt, 70 * CPB);
        repeat (20) tick();

        // Back-to-back: frame pulse in the first idle cycle after packet_done.
        pulse_eof();
        cnt = 0;
        while (!packet_done && cnt < 400) begin
            tick();
            cnt++;
        end
        check_lit("done_seen", int'(packet_done), 1);
        tick();
        check_lit("busy_after_done", int'(busy), 0);
        pulse_eof();
        check_lit("b2b_restart_busy", int'(busy), 1);
        wait_idle();
        repeat (5) tick();

        // Reset during B3 data bits, then a fresh packet.
        pulse_eof();
        repeat (130) tick();
        rst = 1'b1;
        tick();
        check_lit("midrst_tx", int'(tx), 1);
        check_lit("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (10) tick();
        pulse_eof();
        wait_idle();
        repeat (5) tick();

        // Max values.
        x = 11'd2047; y = 11'd2047; p1 = 4'd15; p2 = 4'd15;
        pulse_eof();
        wait_idle();
        repeat (5) tick();

        // Random traffic with occasional resets and enable drops.
        repeat (4000) begin
            en  = ($urandom_range(0, 9) != 0);
            eof = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 799) == 0);
            x   = 11'($urandom);
            y   = 11'($urandom);
            p1  = 4'($urandom);
            p2  = 4'($urandom);
            tick();
        end
        rst = 1'b0;
        eof = 1'b0;
        wait_idle();
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
